// File: rtl/ccc_pll_seq_ctrl.sv
// CCC/PLL power-up and lock supervisor: sequences PLL power-down/reset, qualifies LOCK, releases fabric reset.
// Optional feature macro: CCC_SEQ_LOSS_RECOVERY_EN (lock loss in RUN re-enters ARST instead of FAULT).
module ccc_pll_seq_ctrl #(
    parameter int ARST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       RESTART,
    input  logic       LOCK,
    output logic       PLL_POWERDOWN_N,
    output logic       PLL_ARST_N,
    output logic       FAB_RESET_N,
    output logic       READY,
    output logic       FAULT,
    output logic [3:0] RETRY_CNT,
    output logic [7:0] LOSS_CNT
);
    localparam int ARST_W = (ARST_CYCLES > 1) ? $clog2(ARST_CYCLES) : 1;
    localparam int TO_W   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int ST_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    // Each counter starts at 0 on entry, so "limit reached" is a match against limit-1.
    localparam logic [ARST_W-1:0] ARST_LAST = ARST_W'(ARST_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [ST_W-1:0]   ST_LAST   = ST_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_OFF, S_ARST, S_WAIT_LOCK, S_STABLE, S_RUN, S_FAULT
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_lock_meta;
    logic              r_lock_s;
    logic [ARST_W-1:0] r_arst_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [ST_W-1:0]   r_st_cnt;
    logic [3:0]        r_retry_cnt;
    logic [7:0]        r_loss_cnt;
    logic              w_arst_entry;
    logic              w_retry_clr;
    logic              w_retry_inc;
    logic              w_loss_inc;
    logic              w_timeout;
    logic              w_stable_done;
    logic              w_pwrdn_n;
    logic              w_arst_n;
    logic              w_fab_rst_n;
    logic              w_ready;
    logic              w_fault;
    logic              r_pwrdn_n;
    logic              r_arst_n;
    logic              r_fab_rst_n;
    logic              r_ready;
    logic              r_fault;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= LOCK;
            r_lock_s    <= r_lock_meta;
        end
    end

    // NOTE: reset is synchronous, so it only needs to sit first in the clocked if-chain.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_OFF;
            r_arst_cnt  <= '0;
            r_to_cnt    <= '0;
            r_st_cnt    <= '0;
            r_retry_cnt <= '0;
            r_loss_cnt  <= '0;
        end else begin
            r_state <= w_next_state;

            if (w_arst_entry)
                r_arst_cnt <= '0;
            else if (r_state == S_ARST && r_arst_cnt != ARST_LAST)
                r_arst_cnt <= r_arst_cnt + 1'b1;

            // Timeout spans WAIT_LOCK/STABLE bounces; only a fresh ARST restarts it.
            if (w_arst_entry)
                r_to_cnt <= '0;
            else if ((r_state == S_WAIT_LOCK || r_state == S_STABLE) && r_to_cnt != TO_LAST)
                r_to_cnt <= r_to_cnt + 1'b1;

            if (r_state != S_STABLE || w_next_state != S_STABLE)
                r_st_cnt <= '0;
            else if (r_st_cnt != ST_LAST)
                r_st_cnt <= r_st_cnt + 1'b1;

            if (w_retry_clr)
                r_retry_cnt <= '0;
            else if (w_retry_inc)
                r_retry_cnt <= r_retry_cnt + 4'd1;

            if (w_loss_inc && r_loss_cnt != 8'hFF)
                r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state  = r_state;
        w_arst_entry  = 1'b0;
        w_retry_clr   = 1'b0;
        w_retry_inc   = 1'b0;
        w_loss_inc    = 1'b0;
        w_timeout     = (r_to_cnt == TO_LAST);
        w_stable_done = r_lock_s && (r_st_cnt == ST_LAST);

        if (!ENABLE) begin
            w_next_state = S_OFF;
            w_retry_clr  = 1'b1;
        end else if (RESTART) begin
            w_next_state = S_ARST;
            w_arst_entry = 1'b1;
            w_retry_clr  = 1'b1;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_next_state = S_ARST;
                    w_arst_entry = 1'b1;
                end
                S_ARST: begin
                    if (r_arst_cnt == ARST_LAST)
                        w_next_state = S_WAIT_LOCK;
                end
                S_WAIT_LOCK, S_STABLE: begin
                    if (r_state == S_STABLE && w_stable_done) begin
                        w_next_state = S_RUN;
                    end else if (w_timeout) begin
                        if (r_retry_cnt < RETRY_MAX) begin
                            w_retry_inc  = 1'b1;
                            w_next_state = S_ARST;
                            w_arst_entry = 1'b1;
                        end else begin
                            w_next_state = S_FAULT;
                        end
                    end else if (r_state == S_WAIT_LOCK && r_lock_s) begin
                        w_next_state = S_STABLE;
                    end else if (r_state == S_STABLE && !r_lock_s) begin
                        w_next_state = S_WAIT_LOCK;
                    end
                end
                S_RUN: begin
                    if (!r_lock_s) begin
                        w_loss_inc = 1'b1;
`ifdef CCC_SEQ_LOSS_RECOVERY_EN
                        w_next_state = S_ARST;
                        w_arst_entry = 1'b1;
`else
                        w_next_state = S_FAULT;
`endif
                    end
                end
                S_FAULT: w_next_state = S_FAULT;
                default: w_next_state = S_OFF;
            endcase
        end
    end

    // Outputs decode the next state so they register on the same edge as the state change.
    always_comb begin
        w_pwrdn_n   = 1'b0;
        w_arst_n    = 1'b0;
        w_fab_rst_n = 1'b0;
        w_ready     = 1'b0;
        w_fault     = 1'b0;
        case (w_next_state)
            S_ARST:                 w_pwrdn_n = 1'b1;
            S_WAIT_LOCK, S_STABLE: begin
                w_pwrdn_n = 1'b1;
                w_arst_n  = 1'b1;
            end
            S_RUN: begin
                w_pwrdn_n   = 1'b1;
                w_arst_n    = 1'b1;
                w_fab_rst_n = 1'b1;
                w_ready     = 1'b1;
            end
            S_FAULT:                w_fault = 1'b1;
            default:                w_pwrdn_n = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pwrdn_n   <= 1'b0;
            r_arst_n    <= 1'b0;
            r_fab_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_pwrdn_n   <= w_pwrdn_n;
            r_arst_n    <= w_arst_n;
            r_fab_rst_n <= w_fab_rst_n;
            r_ready     <= w_ready;
            r_fault     <= w_fault;
        end
    end

    assign PLL_POWERDOWN_N = r_pwrdn_n;
    assign PLL_ARST_N      = r_arst_n;
    assign FAB_RESET_N     = r_fab_rst_n;
    assign READY           = r_ready;
    assign FAULT           = r_fault;
    assign RETRY_CNT       = r_retry_cnt;
    assign LOSS_CNT        = r_loss_cnt;

endmodule

// File: tb/tb_ccc_pll_seq_ctrl.sv
// Scoreboard bench for ccc_pll_seq_ctrl: a timestamp-based reference model predicts outputs per edge,
// a monitor compares them; directed checks cover the bring-up, timeout, loss and override cases.
module tb_ccc_pll_seq_ctrl;
    localparam int ARST_CYCLES   = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;

    logic       clk = 1'b0;
    logic       reset, enable, restart, lock;
    logic       pll_powerdown_n, pll_arst_n, fab_reset_n, ready, fault;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    always #5 clk = ~clk;

    ccc_pll_seq_ctrl #(
        .ARST_CYCLES  (ARST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .CLK            (clk),
        .RESET          (reset),
        .ENABLE         (enable),
        .RESTART        (restart),
        .LOCK           (lock),
        .PLL_POWERDOWN_N(pll_powerdown_n),
        .PLL_ARST_N     (pll_arst_n),
        .FAB_RESET_N    (fab_reset_n),
        .READY          (ready),
        .FAULT          (fault),
        .RETRY_CNT      (retry_cnt),
        .LOSS_CNT       (loss_cnt)
    );

    typedef struct packed {
        logic       pwr;
        logic       arst;
        logic       fab;
        logic       rdy;
        logic       flt;
        logic [3:0] retry;
        logic [7:0] loss;
    } obs_t;

    typedef enum int {M_OFF, M_ARST, M_WAIT, M_RUN, M_FAULT} mode_t;

    obs_t  exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    // Reference model: phases plus the edge index at which each phase began.
    mode_t m_mode = M_OFF;
    int    m_t = 0, m_arst_t0 = 0, m_wait_t0 = 0, m_stable_t0 = -1;
    int    m_retry = 0, m_loss = 0;
    bit    m_lk[$];

    // Directed-check bookkeeping, sampled at negedge.
    bit    chk_low = 0, chk_gap = 0;
    bit    prev_arst = 0;
    int    low_len = 0, last_rise = 0, n_rise = 0, n_ready = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void enter_arst();
        m_mode    = M_ARST;
        m_arst_t0 = m_t;
    endfunction

    function automatic void model_edge();
        bit lock_s;
        lock_s = m_lk.pop_front();
        m_lk.push_back(lock);
        m_t++;
        if (reset) begin
            m_mode  = M_OFF;
            m_retry = 0;
            m_loss  = 0;
            m_lk.delete();
            m_lk.push_back(1'b0);
            m_lk.push_back(1'b0);
        end else if (!enable) begin
            m_mode  = M_OFF;
            m_retry = 0;
        end else if (restart) begin
            enter_arst();
            m_retry = 0;
        end else begin
            case (m_mode)
                M_OFF: enter_arst();
                M_ARST: if (m_t - m_arst_t0 == ARST_CYCLES) begin
                    m_mode      = M_WAIT;
                    m_wait_t0   = m_t;
                    m_stable_t0 = -1;
                end
                M_WAIT: begin
                    if (m_stable_t0 >= 0 && lock_s && m_t - m_stable_t0 == STABLE_CYCLES)
                        m_mode = M_RUN;
                    else if (m_t - m_wait_t0 == LOCK_TIMEOUT) begin
                        if (m_retry < MAX_RETRIES) begin
                            m_retry++;
                            enter_arst();
                        end else m_mode = M_FAULT;
                    end else if (!lock_s) m_stable_t0 = -1;
                    else if (m_stable_t0 < 0) m_stable_t0 = m_t;
                end
                M_RUN: if (!lock_s) begin
                    if (m_loss < 255) m_loss++;
`ifdef CCC_SEQ_LOSS_RECOVERY_EN
                    enter_arst();
`else
                    m_mode = M_FAULT;
`endif
                end
                default: ;
            endcase
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o       = '0;
        o.retry = 4'(m_retry);
        o.loss  = 8'(m_loss);
        case (m_mode)
            M_ARST:  o.pwr = 1'b1;
            M_WAIT:  begin o.pwr = 1'b1; o.arst = 1'b1; end
            M_RUN:   begin o.pwr = 1'b1; o.arst = 1'b1; o.fab = 1'b1; o.rdy = 1'b1; end
            M_FAULT: o.flt = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    // One clock of stimulus: drive, predict, then observe at the following negedge.
    task automatic step(input bit a_rst, input bit a_en, input bit a_rs, input bit a_lk);
        reset   = a_rst;
        enable  = a_en;
        restart = a_rs;
        lock    = a_lk;
        model_edge();
        exp_q.push_back(model_obs());
        @(negedge clk);
        if (pll_powerdown_n && !pll_arst_n) low_len++;
        if (pll_arst_n && !prev_arst) begin
            n_rise++;
            if (chk_low) check("arst_low_cycles", 32'(low_len), 32'(ARST_CYCLES));
            last_rise = m_t;
        end
        if (!pll_arst_n && prev_arst && chk_gap)
            check("timeout_gap", 32'(m_t - last_rise), 32'(LOCK_TIMEOUT));
        if (!(pll_powerdown_n && !pll_arst_n)) low_len = 0;
        if (ready) n_ready++;
        prev_arst = pll_arst_n;
    endtask

    always @(posedge clk) begin
        obs_t e, a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pll_powerdown_n, pll_arst_n, fab_reset_n, ready, fault, retry_cnt, loss_cnt};
            check($sformatf("outputs@edge%0d", m_t - exp_q.size()), 32'(a), 32'(e));
        end
    end

    initial begin
        int guard;
        int rise0;
        reset = 1'b1; enable = 1'b0; restart = 1'b0; lock = 1'b0;
        m_lk.push_back(1'b0);
        m_lk.push_back(1'b0);
        @(negedge clk);
        repeat (3) step(1, 0, 0, 0);
        check("reset_pwrdn_n", 32'(pll_powerdown_n), 32'd0);

        // Nominal bring-up.
        chk_low = 1;
        step(0, 1, 0, 0);
        check("enable_pwrdn_n", 32'(pll_powerdown_n), 32'd1);
        guard = 0;
        while (m_mode != M_WAIT && guard < 20) begin step(0, 1, 0, 0); guard++; end
        repeat (4) step(0, 1, 0, 0);
        repeat (30) step(0, 1, 0, 1);
        check("nominal_ready", 32'(ready), 32'd1);
        check("nominal_fab", 32'(fab_reset_n), 32'd1);
        check("nominal_retry", 32'(retry_cnt), 32'd0);

        // Lock loss in RUN: fabric reset falls on the third edge.
        repeat (2) step(0, 1, 0, 0);
        check("loss_fab_still_high", 32'(fab_reset_n), 32'd1);
        step(0, 1, 0, 0);
        check("loss_fab_low", 32'(fab_reset_n), 32'd0);
        check("loss_cnt_one", 32'(loss_cnt), 32'd1);
`ifdef CCC_SEQ_LOSS_RECOVERY_EN
        repeat (30) step(0, 1, 0, 1);
        check("loss_recovered", 32'(ready), 32'd1);
`else
        check("loss_fault", 32'(fault), 32'd1);
`endif

        // Lock never asserts: three ARST pulses, then FAULT.
        repeat (2) step(0, 0, 0, 0);
        chk_gap = 1;
        rise0   = n_rise;
        repeat (130) step(0, 1, 0, 0);
        check("never_rises", 32'(n_rise - rise0), 32'd3);
        check("never_fault", 32'(fault), 32'd1);
        check("never_retry", 32'(retry_cnt), 32'd2);
        check("never_pwrdn_n", 32'(pll_powerdown_n), 32'd0);

        // RESTART in FAULT.
        step(0, 1, 1, 0);
        check("restart_retry", 32'(retry_cnt), 32'd0);
        check("restart_arst", 32'({pll_powerdown_n, pll_arst_n, fault}), 32'b100);

        // Chattering lock: toggles every 5 cycles, never qualifies.
        n_ready = 0;
        for (int i = 0; i < 130; i++) step(0, 1, 0, (i / 5) % 2 == 1);
        check("chatter_no_ready", 32'(n_ready), 32'd0);
        check("chatter_retry", 32'(retry_cnt), 32'd2);
        check("chatter_fault", 32'(fault), 32'd1);
        chk_gap = 0;
        chk_low = 0;

        // ENABLE drop mid-STABLE.
        step(0, 1, 1, 1);
        guard = 0;
        while (m_stable_t0 < 0 && guard < 30) begin step(0, 1, 0, 1); guard++; end
        repeat (2) step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        check("disable_off", 32'({pll_powerdown_n, pll_arst_n, fab_reset_n}), 32'b000);

        // RESET mid-ARST.
        repeat (2) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        check("reset_outputs",
              32'({pll_powerdown_n, pll_arst_n, fab_reset_n, ready, fault, retry_cnt, loss_cnt}), 32'd0);

        // 300 lock-loss events: LOSS_CNT saturates.
        for (int e = 0; e < 300; e++) begin
            guard = 0;
            while (m_mode != M_RUN && guard < 100) begin
                step(0, 1, (m_mode == M_FAULT), 1);
                guard++;
            end
            repeat (3) step(0, 1, 0, 0);
        end
        check("loss_saturated", 32'(loss_cnt), 32'd255);

        // Randomized stretches of lock/enable/restart/reset.
        for (int c = 0; c < 150; c++) begin
            bit lvl, en_c;
            int len;
            lvl  = 1'($urandom_range(0, 1));
            en_c = ($urandom_range(0, 9) != 0);
            len  = $urandom_range(1, 40);
            for (int i = 0; i < len; i++)
                step(($urandom_range(0, 299) == 0), en_c, ($urandom_range(0, 39) == 0), lvl);
        end

        repeat (2) step(0, 0, 0, 0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
